// File: rtl/player_executor.sv
// player_executor: receiving end of the Machine -> player instruction bus.
// Decodes {op[15:12], arg[11:4], 4'b0} and keeps the player's HP, soul
// position, invulnerability and death state. It also runs the damage
// request handshake towards Machine.
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   playerInstruction[15:0]   {op, arg, 4'b0}; op 1 HPY 2 DPY 3 IDG 4 SDG 5 MOV 6 SHP
//   isMove                    qualifies MOV this cycle
//   startDmg                  strobe: execute HPY/DPY on the bus, close request
//   hit                       collision pulse from the bullet logic
//   isDmgComplete             damage request pending to Machine
//   isDeath                   sticky, HP reached 0
//   invuln                    damage is being ignored
//   hp[7:0], posX/posY[9:0]   HP and top-left soul pixel for the renderer
module player_executor #(
   parameter int unsigned MAX_HP     = 100,
   parameter int unsigned BOX_X0     = 220,
   parameter int unsigned BOX_X1     = 420,
   parameter int unsigned BOX_Y0     = 260,
   parameter int unsigned BOX_Y1     = 420,
   parameter int unsigned STEP       = 4,
   parameter int unsigned MOVE_DIV   = 250000,
   parameter int unsigned INVULN_CYC = 100000000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [15:0] playerInstruction,
   input  logic        isMove,
   input  logic        startDmg,
   input  logic        hit,
   output logic        isDmgComplete,
   output logic        isDeath,
   output logic        invuln,
   output logic [7:0]  hp,
   output logic [9:0]  posX,
   output logic [9:0]  posY
);

   localparam int unsigned IW = $clog2(INVULN_CYC + 1);
   localparam int unsigned CW = $clog2(MOVE_DIV + 1);

   localparam logic [9:0] X_MID   = 10'((BOX_X0 + BOX_X1) / 2);
   localparam logic [9:0] Y_MID   = 10'((BOX_Y0 + BOX_Y1) / 2);
   localparam logic [9:0] X_LO    = 10'(BOX_X0);
   localparam logic [9:0] X_HI    = 10'(BOX_X1);
   localparam logic [9:0] Y_LO    = 10'(BOX_Y0);
   localparam logic [9:0] Y_HI    = 10'(BOX_Y1);
   localparam logic [9:0] X_LO_ST = 10'(BOX_X0 + STEP);
   localparam logic [9:0] X_HI_ST = 10'(BOX_X1 - STEP);
   localparam logic [9:0] Y_LO_ST = 10'(BOX_Y0 + STEP);
   localparam logic [9:0] Y_HI_ST = 10'(BOX_Y1 - STEP);
   localparam logic [9:0] STEP10  = 10'(STEP);
   localparam logic [7:0] HP_MAX8 = 8'(MAX_HP);
   localparam logic [8:0] HP_MAX9 = 9'(MAX_HP);

   localparam logic [3:0] OP_HPY = 4'd1;
   localparam logic [3:0] OP_DPY = 4'd2;
   localparam logic [3:0] OP_IDG = 4'd3;
   localparam logic [3:0] OP_SDG = 4'd4;
   localparam logic [3:0] OP_MOV = 4'd5;
   localparam logic [3:0] OP_SHP = 4'd6;

   typedef enum logic {S_IDLE = 1'b0, S_PEND = 1'b1} dmg_state_t;

   dmg_state_t      r_state, w_state_nxt;
   logic [7:0]      r_hp;
   logic [9:0]      r_posX, r_posY;
   logic            r_death, r_invuln;
   logic [IW-1:0]   r_icnt;
   logic [CW-1:0]   r_cool;

   logic [3:0]      w_op;
   logic [7:0]      w_arg;
   logic [8:0]      w_hp_sum;
   logic [7:0]      w_hp_dmg;
   logic            w_dmg_ok;
   logic            w_mov_ok;
   logic [9:0]      w_x_nxt, w_y_nxt;
   logic            w_unused;

   assign w_op     = playerInstruction[15:12];
   assign w_arg    = playerInstruction[11:4];
   assign w_unused = ^playerInstruction[3:0];

   assign w_hp_sum = {1'b0, r_hp} + {1'b0, w_arg};
   assign w_hp_dmg = (w_arg >= r_hp) ? 8'd0 : r_hp - w_arg;
   assign w_dmg_ok = startDmg && (w_op == OP_DPY) && !r_invuln && !r_death;
   assign w_mov_ok = (w_op == OP_MOV) && isMove && (r_cool == '0) && (w_arg < 8'd4);

   // Clamped one-step move target for the requested direction
   always_comb begin
      w_x_nxt = r_posX;
      w_y_nxt = r_posY;
      case (w_arg)
         8'd0:    w_y_nxt = (r_posY < Y_LO_ST) ? Y_LO : r_posY - STEP10;
         8'd1:    w_x_nxt = (r_posX < X_LO_ST) ? X_LO : r_posX - STEP10;
         8'd2:    w_y_nxt = (r_posY > Y_HI_ST) ? Y_HI : r_posY + STEP10;
         8'd3:    w_x_nxt = (r_posX > X_HI_ST) ? X_HI : r_posX + STEP10;
         default: ;
      endcase
   end

   // Damage request handshake state register
   always_ff @(posedge clk) begin
      if (rst) r_state <= S_IDLE;
      else     r_state <= w_state_nxt;
   end

   // startDmg (or SHP) closes the request and beats a simultaneous hit
   always_comb begin
      w_state_nxt = r_state;
      if ((w_op == OP_SHP) || startDmg)
         w_state_nxt = S_IDLE;
      else if ((r_state == S_IDLE) && hit && !r_invuln && !r_death)
         w_state_nxt = S_PEND;
   end

   // Player state: HP, position, invulnerability, cooldowns
   always_ff @(posedge clk) begin
      if (rst) begin
         r_hp     <= 8'd0;
         r_posX   <= X_MID;
         r_posY   <= Y_MID;
         r_death  <= 1'b0;
         r_invuln <= 1'b0;
         r_icnt   <= '0;
         r_cool   <= '0;
      end else begin
         if (r_cool != '0) r_cool <= r_cool - CW'(1);
         // invuln falls one cycle after the counter has reached zero
         if (r_icnt != '0) r_icnt <= r_icnt - IW'(1);
         else              r_invuln <= 1'b0;

         case (w_op)
            OP_SHP: begin
               r_hp     <= (w_arg > HP_MAX8) ? HP_MAX8 : w_arg;
               r_posX   <= X_MID;
               r_posY   <= Y_MID;
               r_death  <= 1'b0;
               r_invuln <= 1'b0;
               r_icnt   <= '0;
               r_cool   <= '0;
            end
            OP_HPY: begin
               if (startDmg) r_hp <= (w_hp_sum > HP_MAX9) ? HP_MAX8 : w_hp_sum[7:0];
            end
            OP_DPY: begin
               if (w_dmg_ok) begin
                  r_hp     <= w_hp_dmg;
                  r_invuln <= 1'b1;
                  r_icnt   <= IW'(INVULN_CYC);
                  if (w_hp_dmg == 8'd0) r_death <= 1'b1;
               end
            end
            OP_IDG: begin
               r_invuln <= 1'b1;
               r_icnt   <= IW'(INVULN_CYC);
            end
            OP_SDG: begin
               r_invuln <= 1'b0;
               r_icnt   <= '0;
            end
            OP_MOV: begin
               if (w_mov_ok) begin
                  r_posX <= w_x_nxt;
                  r_posY <= w_y_nxt;
                  r_cool <= CW'(MOVE_DIV - 1);
               end
            end
            default: ;
         endcase
      end
   end

   assign isDmgComplete = (r_state == S_PEND);
   assign isDeath       = r_death;
   assign invuln        = r_invuln;
   assign hp            = r_hp;
   assign posX          = r_posX;
   assign posY          = r_posY;

endmodule

// File: tb/tb_player_executor.sv
// Self-checking bench for player_executor: directed scenarios plus a random
// run, all compared against a timestamp-based reference model of the player.
module tb_player_executor;

   localparam int MOVE_DIV   = 8;
   localparam int INVULN_CYC = 40;

   logic        clk = 1'b0;
   logic        rst;
   logic [15:0] instr;
   logic        is_move, start_dmg, hit;
   logic        dmg_pend, is_death, invuln;
   logic [7:0]  hp;
   logic [9:0]  pos_x, pos_y;

   int n_pass  = 0;
   int n_total = 0;

   always #5 clk = ~clk;

   player_executor #(
      .MOVE_DIV   (MOVE_DIV),
      .INVULN_CYC (INVULN_CYC)
   ) dut (
      .clk               (clk),
      .rst               (rst),
      .playerInstruction (instr),
      .isMove            (is_move),
      .startDmg          (start_dmg),
      .hit               (hit),
      .isDmgComplete     (dmg_pend),
      .isDeath           (is_death),
      .invuln            (invuln),
      .hp                (hp),
      .posX              (pos_x),
      .posY              (pos_y)
   );

   // Reference model: invulnerability and move cooldown are kept as absolute
   // edge-number windows instead of down-counters.
   int    m_hp, m_x, m_y;
   bit    m_pend, m_death, m_inv_act;
   longint m_inv_end, m_next_mov, ecount = 0;

   function automatic int imin(int a, int b); return (a < b) ? a : b; endfunction
   function automatic int imax(int a, int b); return (a > b) ? a : b; endfunction

   function automatic bit inv_now();
      return m_inv_act && (ecount <= m_inv_end);
   endfunction

   function automatic void model_step();
      longint e   = ecount + 1;
      int     op  = int'(instr[15:12]);
      int     arg = int'(instr[11:4]);
      bit     inv = inv_now();
      bit     n_pend = m_pend;
      if (rst) begin
         m_hp = 0; m_x = 320; m_y = 340; m_death = 0; m_inv_act = 0;
         m_next_mov = 0; n_pend = 0;
      end else if (op == 6) begin
         m_hp = imin(arg, 100); m_x = 320; m_y = 340; m_death = 0;
         m_inv_act = 0; m_next_mov = 0; n_pend = 0;
      end else begin
         if (start_dmg) n_pend = 0;
         else if (!m_pend && hit && !inv && !m_death) n_pend = 1;
         case (op)
            1: if (start_dmg) m_hp = imin(m_hp + arg, 100);
            2: if (start_dmg && !inv && !m_death) begin
                  m_hp = (arg >= m_hp) ? 0 : m_hp - arg;
                  m_inv_act = 1; m_inv_end = e + INVULN_CYC;
                  if (m_hp == 0) m_death = 1;
               end
            3: begin m_inv_act = 1; m_inv_end = e + INVULN_CYC; end
            4: m_inv_act = 0;
            5: if (is_move && arg <= 3 && e >= m_next_mov) begin
                  case (arg)
                     0: m_y = imax(m_y - 4, 260);
                     1: m_x = imax(m_x - 4, 220);
                     2: m_y = imin(m_y + 4, 420);
                     default: m_x = imin(m_x + 4, 420);
                  endcase
                  m_next_mov = e + MOVE_DIV;
               end
            default: ;
         endcase
      end
      m_pend = n_pend;
      ecount = e;
   endfunction

   function automatic logic [30:0] exp_vec();
      return {m_pend, m_death, inv_now(), 8'(m_hp), 10'(m_x), 10'(m_y)};
   endfunction

   function automatic logic [30:0] obs_vec();
      return {dmg_pend, is_death, invuln, hp, pos_x, pos_y};
   endfunction

   function automatic logic [15:0] ins(input int op, input int arg);
      return {4'(op), 8'(arg), 4'b0};
   endfunction

   task automatic cyc();
      @(posedge clk);
      model_step();
      #1;
   endtask

   task automatic idle_inputs();
      instr = 16'h0; is_move = 0; start_dmg = 0; hit = 0; rst = 0;
   endtask

   task automatic test_reset();
      idle_inputs(); rst = 1; cyc(); rst = 0;
      n_total++;
      if ({dmg_pend, is_death, invuln, hp, pos_x, pos_y} !== {3'b000, 8'd0, 10'd320, 10'd340})
         $display("FAIL reset_state: got p%0b d%0b i%0b hp%0d (%0d,%0d) want 000 hp0 (320,340)",
                  dmg_pend, is_death, invuln, hp, pos_x, pos_y);
      else n_pass++;
      instr = ins(6, 100); cyc(); instr = 0;
      n_total++;
      if ({is_death, hp, pos_x, pos_y} !== {1'b0, 8'd100, 10'd320, 10'd340})
         $display("FAIL shp_init: got d%0b hp%0d (%0d,%0d) want d0 hp100 (320,340)",
                  is_death, hp, pos_x, pos_y);
      else n_pass++;
      instr = ins(6, 200); cyc(); instr = 0;
      n_total++;
      if (hp !== 8'd100) $display("FAIL shp_clamp: got hp=%0d want 100", hp);
      else n_pass++;
   endtask

   task automatic test_damage();
      hit = 1; cyc(); hit = 0;
      n_total++;
      if (dmg_pend !== 1'b1) $display("FAIL hit_request: got %0b want 1", dmg_pend);
      else n_pass++;
      instr = ins(2, 30); start_dmg = 1; cyc(); start_dmg = 0; instr = 0;
      n_total++;
      if ({hp, dmg_pend, invuln} !== {8'd70, 1'b0, 1'b1})
         $display("FAIL dpy_apply: got hp%0d p%0b i%0b want hp70 p0 i1", hp, dmg_pend, invuln);
      else n_pass++;
      hit = 1; cyc(); hit = 0; cyc();
      n_total++;
      if (dmg_pend !== 1'b0) $display("FAIL hit_invuln: got %0b want 0", dmg_pend);
      else n_pass++;
      for (int i = 0; i < 45; i++) begin
         cyc();
         n_total++;
         if (invuln !== inv_now()) $display("FAIL invuln_expiry[%0d]: got %0b want %0b", i, invuln, inv_now());
         else n_pass++;
      end
      hit = 1; cyc(); hit = 0;
      n_total++;
      if (dmg_pend !== 1'b1) $display("FAIL hit_after_expiry: got %0b want 1", dmg_pend);
      else n_pass++;
   endtask

   task automatic test_death();
      instr = ins(6, 20); cyc();
      instr = ins(2, 50); start_dmg = 1; cyc(); start_dmg = 0; instr = 0;
      n_total++;
      if ({hp, is_death} !== {8'd0, 1'b1}) $display("FAIL dpy_kill: got hp%0d d%0b want hp0 d1", hp, is_death);
      else n_pass++;
      instr = ins(4, 0); cyc(); instr = 0;
      hit = 1; cyc(); hit = 0; cyc();
      n_total++;
      if ({dmg_pend, is_death} !== 2'b01) $display("FAIL hit_dead: got p%0b d%0b want p0 d1", dmg_pend, is_death);
      else n_pass++;
      instr = ins(5, 3); is_move = 1; cyc(); is_move = 0; instr = 0;
      n_total++;
      if (pos_x !== 10'd324) $display("FAIL move_dead: got posX=%0d want 324", pos_x);
      else n_pass++;
      instr = ins(6, 100); cyc(); instr = 0;
      n_total++;
      if ({is_death, hp} !== {1'b0, 8'd100}) $display("FAIL shp_revive: got d%0b hp%0d want d0 hp100", is_death, hp);
      else n_pass++;
   endtask

   task automatic test_heal();
      instr = ins(6, 95); cyc();
      instr = ins(1, 10); start_dmg = 1; cyc(); start_dmg = 0;
      n_total++;
      if (hp !== 8'd100) $display("FAIL hpy_sat: got hp=%0d want 100", hp);
      else n_pass++;
      instr = ins(6, 50); cyc();
      instr = ins(1, 10); cyc(); cyc(); cyc();
      n_total++;
      if (hp !== 8'd50) $display("FAIL hpy_no_strobe: got hp=%0d want 50", hp);
      else n_pass++;
      start_dmg = 1; cyc(); start_dmg = 0; instr = 0;
      n_total++;
      if (hp !== 8'd60) $display("FAIL hpy_add: got hp=%0d want 60", hp);
      else n_pass++;
   endtask

   task automatic test_move();
      int last = -1;
      int steps = 0;
      logic [9:0] prev;
      instr = ins(6, 100); cyc();
      prev = pos_x;
      instr = ins(5, 1); is_move = 1;
      for (int i = 0; i < 60 * MOVE_DIV; i++) begin
         cyc();
         if (pos_x !== prev) begin
            steps++;
            if (last >= 0) begin
               n_total++;
               if (i - last != MOVE_DIV) $display("FAIL move_spacing: got %0d want %0d", i - last, MOVE_DIV);
               else n_pass++;
            end
            last = i;
            prev = pos_x;
         end
      end
      n_total++;
      if (pos_x !== 10'd220 || steps != 25)
         $display("FAIL move_clamp: got posX=%0d steps=%0d want 220 steps=25", pos_x, steps);
      else n_pass++;
      instr = ins(5, 3); is_move = 0;
      repeat (20) cyc();
      instr = ins(5, 7); is_move = 1;
      repeat (20) cyc();
      is_move = 0; instr = 0;
      n_total++;
      if ({pos_x, pos_y} !== {10'd220, 10'd340})
         $display("FAIL move_ignored: got (%0d,%0d) want (220,340)", pos_x, pos_y);
      else n_pass++;
   endtask

   task automatic test_back_to_back();
      instr = ins(6, 100); cyc();
      instr = ins(2, 30); start_dmg = 1; hit = 1; cyc();
      start_dmg = 0; hit = 0; instr = 0;
      n_total++;
      if ({hp, dmg_pend} !== {8'd70, 1'b0}) $display("FAIL hit_and_dpy: got hp%0d p%0b want hp70 p0", hp, dmg_pend);
      else n_pass++;
      cyc();
      n_total++;
      if (dmg_pend !== 1'b0) $display("FAIL hit_dropped: got %0b want 0", dmg_pend);
      else n_pass++;
      instr = ins(4, 0); cyc(); instr = 0;
      hit = 1; cyc(); hit = 0;
      start_dmg = 1; cyc(); start_dmg = 0;
      n_total++;
      if ({dmg_pend, hp} !== {1'b0, 8'd70}) $display("FAIL sd_noop_clears: got p%0b hp%0d want p0 hp70", dmg_pend, hp);
      else n_pass++;
      instr = ins(3, 0); cyc(); instr = 0; cyc();
      rst = 1; cyc(); rst = 0;
      n_total++;
      if ({invuln, hp, dmg_pend, pos_x, pos_y} !== {1'b0, 8'd0, 1'b0, 10'd320, 10'd340})
         $display("FAIL rst_mid_invuln: got i%0b hp%0d p%0b want i0 hp0 p0", invuln, hp, dmg_pend);
      else n_pass++;
   endtask

   task automatic test_random();
      int errs = 0;
      for (int i = 0; i < 4000; i++) begin
         int r = $urandom_range(0, 99);
         if      (r < 4)  instr = ins(6, $urandom_range(0, 255));
         else if (r < 25) instr = ins(2, $urandom_range(0, 80));
         else if (r < 35) instr = ins(1, $urandom_range(0, 255));
         else if (r < 38) instr = ins(3, 0);
         else if (r < 48) instr = ins(4, 0);
         else if (r < 80) instr = ins(5, $urandom_range(0, 5));
         else             instr = ins($urandom_range(0, 15), $urandom_range(0, 255));
         is_move   = ($urandom_range(0, 9) < 7);
         start_dmg = ($urandom_range(0, 9) < 2);
         hit       = ($urandom_range(0, 3) == 0);
         rst       = ($urandom_range(0, 199) == 0);
         cyc();
         n_total++;
         if (obs_vec() !== exp_vec()) begin
            if (errs < 10) $display("FAIL random[%0d]: got %h want %h", i, obs_vec(), exp_vec());
            errs++;
         end else n_pass++;
      end
      idle_inputs();
   endtask

   initial begin
      idle_inputs();
      test_reset();
      test_damage();
      test_death();
      test_heal();
      test_move();
      test_back_to_back();
      test_random();
      cyc();
      n_total++;
      if (obs_vec() !== exp_vec()) $display("FAIL final_state: got %h want %h", obs_vec(), exp_vec());
      else n_pass++;
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
